// File: rtl/dcache_tag_pkg.sv
// Shared types for the dcache tag-array controller.
//   tag_op_e    : operation codes carried on req_op
//   tag_entry_t : one SRAM word {valid, dirty, tag} at the default tag width
//   tag_state_e : controller FSM states
package dcache_tag_pkg;

  localparam int SET_BITS_DEF = 4;
  localparam int TAG_BITS_DEF = 22;

  typedef enum logic [1:0] {
    OP_LOOKUP     = 2'd0,
    OP_FILL       = 2'd1,
    OP_MARK_DIRTY = 2'd2,
    OP_INVAL      = 2'd3
  } tag_op_e;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [TAG_BITS_DEF-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RMW  = 2'd2
  } tag_state_e;

endpackage

// File: rtl/dcache_tag_ctrl.sv
// Initiator for the 1RW dcache tag SRAM (2**SET_BITS sets x TAG_BITS+2 bits).
// Clears every set after reset, then serves LOOKUP / FILL / MARK_DIRTY / INVAL
// requests from the dcache FSM with a one-cycle registered response.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (accept at posedge)
//   req_op/set/tag/dirty       request fields
//   resp_valid/hit/dirty/tag   response pulse, stored state before the op
//   init_done                  clear sweep finished
//   sram_csb/web/addr/din      SRAM port drive (combinational)
//   sram_dout                  SRAM read data, sampled at end of read cycle
import dcache_tag_pkg::*;

module dcache_tag_ctrl #(
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [TAG_BITS-1:0] req_tag,
  input  logic                req_dirty,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic                resp_dirty,
  output logic [TAG_BITS-1:0] resp_tag,
  output logic                init_done,
  output logic                sram_csb,
  output logic                sram_web,
  output logic [SET_BITS-1:0] sram_addr,
  output logic [TAG_BITS+1:0] sram_din,
  input  logic [TAG_BITS+1:0] sram_dout
);

  localparam int ENT_W = TAG_BITS + 2;

  tag_state_e          state_q;
  tag_op_e             op_q;
  logic [SET_BITS-1:0] cnt_q, set_q;
  logic [TAG_BITS-1:0] tag_q;
  logic                pend_q;  // a response is due at the next posedge
  logic                resp_valid_q, resp_hit_q, resp_dirty_q, init_done_q;
  logic [TAG_BITS-1:0] resp_tag_q;

  tag_op_e             req_op_e;
  logic                st_valid, st_dirty, hit;
  logic [TAG_BITS-1:0] st_tag;

  assign req_op_e = tag_op_e'(req_op);
  assign st_valid = sram_dout[ENT_W-1];
  assign st_dirty = sram_dout[ENT_W-2];
  assign st_tag   = sram_dout[TAG_BITS-1:0];
  // Only meaningful while the read issued at the last accept is on dout.
  assign hit      = st_valid && (st_tag == tag_q);

  // SRAM drive. Held idle while in reset so nothing new is captured.
  always_comb begin
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    if (rst_n) begin
      case (state_q)
        ST_INIT: begin
          sram_csb  = 1'b0;
          sram_web  = 1'b0;
          sram_addr = cnt_q;
        end
        ST_IDLE: begin
          if (req_valid) begin
            sram_csb  = 1'b0;
            sram_addr = req_set;
            if (req_op_e == OP_FILL) begin
              sram_web = 1'b0;
              sram_din = {1'b1, req_dirty, req_tag};
            end else if (req_op_e == OP_INVAL) begin
              sram_web = 1'b0;
            end
          end
        end
        ST_RMW: begin
          // Miss leaves the entry untouched; hit rewrites it with dirty set.
          if (hit) begin
            sram_csb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = set_q;
            sram_din  = {2'b11, st_tag};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      op_q         <= OP_LOOKUP;
      set_q        <= '0;
      tag_q        <= '0;
      pend_q       <= 1'b0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_dirty_q <= 1'b0;
      resp_tag_q   <= '0;
    end else begin
      resp_valid_q <= pend_q;
      if (pend_q) begin
        if (op_q == OP_LOOKUP || op_q == OP_MARK_DIRTY) begin
          resp_hit_q   <= hit;
          resp_dirty_q <= st_dirty;
          resp_tag_q   <= st_tag;
        end else begin
          resp_hit_q   <= 1'b0;
          resp_dirty_q <= 1'b0;
          resp_tag_q   <= '0;
        end
      end
      pend_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q     <= ST_IDLE;
            init_done_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            pend_q <= 1'b1;
            op_q   <= req_op_e;
            set_q  <= req_set;
            tag_q  <= req_tag;
            if (req_op_e == OP_MARK_DIRTY) state_q <= ST_RMW;
          end
        end
        ST_RMW:  state_q <= ST_IDLE;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_dirty = resp_dirty_q;
  assign resp_tag   = resp_tag_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: SRAM behavioural model, array-level reference
// model checked every cycle, plus directed literal expectations.
module tb_dcache_tag_ctrl;
  import dcache_tag_pkg::*;

  localparam int SB = 4, TB = 22, EW = 24, NSETS = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'd0;
  logic [SB-1:0] req_set = '0;
  logic [TB-1:0] req_tag = '0;
  logic          req_dirty = 1'b0;
  logic          req_ready, resp_valid, resp_hit, resp_dirty, init_done;
  logic [TB-1:0] resp_tag;
  logic          sram_csb, sram_web;
  logic [SB-1:0] sram_addr;
  logic [EW-1:0] sram_din, sram_dout;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dcache_tag_ctrl #(.SET_BITS(SB), .TAG_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_set(req_set), .req_tag(req_tag), .req_dirty(req_dirty),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_dirty(resp_dirty),
    .resp_tag(resp_tag), .init_done(init_done),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM: capture at posedge, write/read at negedge, dout X after next posedge.
  logic [EW-1:0] ram [NSETS];
  logic          c_csb = 1'b1, c_web = 1'b1;
  logic [SB-1:0] c_addr = '0;
  logic [EW-1:0] c_din = '0;
  always @(posedge clk) begin
    c_csb     <= sram_csb;
    c_web     <= sram_web;
    c_addr    <= sram_addr;
    c_din     <= sram_din;
    sram_dout <= 'x;
  end
  always @(negedge clk)
    if (!c_csb) begin
      if (!c_web) ram[c_addr] <= c_din;
      else        sram_dout   <= ram[c_addr];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tag store as an array, responses one cycle after accept.
  tag_entry_t    m_mem [NSETS];
  int            m_cnt;
  logic          m_rmw, m_pend, p_hit, p_dirty, e_vld, e_hit, e_dirty;
  logic [TB-1:0] p_tag, e_tag;
  logic          m_ready;
  assign m_ready = (m_cnt == NSETS) && !m_rmw;

  always @(posedge clk or negedge rst_n) begin
    tag_entry_t e;
    logic       h;
    if (!rst_n) begin
      m_cnt <= 0; m_rmw <= 0; m_pend <= 0;
      p_hit <= 0; p_dirty <= 0; p_tag <= '0;
      e_vld <= 0; e_hit <= 0; e_dirty <= 0; e_tag <= '0;
    end else begin
      e_vld <= m_pend;
      if (m_pend) begin e_hit <= p_hit; e_dirty <= p_dirty; e_tag <= p_tag; end
      m_pend <= 0;
      m_rmw  <= 0;
      if (m_cnt < NSETS) begin
        m_mem[m_cnt] <= '0;
        m_cnt        <= m_cnt + 1;
      end else if (req_valid && !m_rmw) begin
        e = m_mem[req_set];
        h = e.valid && (e.tag == req_tag);
        m_pend  <= 1;
        p_hit   <= 0; p_dirty <= 0; p_tag <= '0;
        case (tag_op_e'(req_op))
          OP_LOOKUP: begin p_hit <= h; p_dirty <= e.dirty; p_tag <= e.tag; end
          OP_MARK_DIRTY: begin
            p_hit <= h; p_dirty <= e.dirty; p_tag <= e.tag;
            m_rmw <= 1;
            if (h) m_mem[req_set] <= {1'b1, 1'b1, e.tag};
          end
          OP_FILL:  m_mem[req_set] <= {1'b1, req_dirty, req_tag};
          default:  m_mem[req_set] <= '0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("ready", req_ready, m_ready);
      chk("init_done", init_done, m_cnt == NSETS);
      chk("resp_valid", resp_valid, e_vld);
      if (e_vld) begin
        chk("resp_hit", resp_hit, e_hit);
        chk("resp_dirty", resp_dirty, e_dirty);
        chk("resp_tag", resp_tag, e_tag);
      end
    end
  end

  task automatic send(input logic [1:0] op, input int set, input logic [TB-1:0] tag,
                      input logic d);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_op = op; req_set = set[SB-1:0]; req_tag = tag; req_dirty = d;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic expect_resp(input string nm, input logic h, input logic d,
                             input logic [TB-1:0] t);
    @(posedge clk); #1;
    chk({nm, "_vld"}, resp_valid, 1);
    chk({nm, "_hit"}, resp_hit, h);
    chk({nm, "_dirty"}, resp_dirty, d);
    chk({nm, "_tag"}, resp_tag, t);
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_csb"}, sram_csb, 1);
    chk({nm, "_ready"}, req_ready, 0);
    chk({nm, "_rvld"}, resp_valid, 0);
    chk({nm, "_rhit"}, resp_hit, 0);
    chk({nm, "_rdirty"}, resp_dirty, 0);
    chk({nm, "_rtag"}, resp_tag, 0);
    chk({nm, "_idone"}, init_done, 0);
  endtask

  // Called right after reset release at a negedge.
  task automatic sweep_chk();
    for (int i = 0; i < NSETS; i++) begin
      #1;
      chk("sweep_csb", sram_csb, 0);
      chk("sweep_web", sram_web, 0);
      chk("sweep_addr", sram_addr, i);
      chk("sweep_din", sram_din, 0);
      @(negedge clk);
    end
    #1;
    chk("sweep_done", init_done, 1);
    chk("sweep_ready", req_ready, 1);
  endtask

  initial begin
    rst_n = 1;
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #1 rst_chk("rst0");
    @(negedge clk); rst_n = 1;
    sweep_chk();

    send(OP_LOOKUP, 3, 22'h000123, 0);
    expect_resp("lk_empty", 0, 0, 22'h0);

    send(OP_FILL, 5, 22'h2ABCDE, 0);
    send(OP_LOOKUP, 5, 22'h2ABCDE, 0);
    expect_resp("lk_hit", 1, 0, 22'h2ABCDE);

    send(OP_LOOKUP, 5, 22'h000001, 0);
    expect_resp("lk_miss", 0, 0, 22'h2ABCDE);

    send(OP_MARK_DIRTY, 5, 22'h2ABCDE, 0);
    chk("md_busy", req_ready, 0);
    @(negedge clk); #1;
    chk("md_csb", sram_csb, 0);
    chk("md_web", sram_web, 0);
    chk("md_addr", sram_addr, 5);
    chk("md_din", sram_din, {2'b11, 22'h2ABCDE});
    expect_resp("md_hit", 1, 0, 22'h2ABCDE);

    send(OP_LOOKUP, 5, 22'h2ABCDE, 0);
    expect_resp("lk_dirty", 1, 1, 22'h2ABCDE);

    send(OP_MARK_DIRTY, 6, 22'h000055, 0);
    @(negedge clk); #1;
    chk("md_miss_csb", sram_csb, 1);
    expect_resp("md_miss", 0, 0, 22'h0);

    send(OP_INVAL, 5, 22'h0, 0);
    send(OP_LOOKUP, 5, 22'h2ABCDE, 0);
    expect_resp("inval", 0, 0, 22'h0);

    // back-to-back traffic, checked by the per-cycle model
    send(OP_FILL, 9, 22'h3FFFFF, 1);
    send(OP_LOOKUP, 9, 22'h3FFFFF, 0);
    send(OP_LOOKUP, 9, 22'h000000, 0);
    send(OP_FILL, 0, 22'h012345, 0);
    send(OP_LOOKUP, 15, 22'h000000, 0);
    send(OP_LOOKUP, 0, 22'h012345, 0);
    expect_resp("lk_set0", 1, 0, 22'h012345);

    // reset at sweep step 7
    @(negedge clk); #2 rst_n = 0;
    @(negedge clk); rst_n = 1;
    repeat (7) @(negedge clk);
    #1 chk("step7_addr", sram_addr, 7);
    #1 rst_n = 0;
    #1 rst_chk("rst_sweep");
    @(negedge clk); rst_n = 1;
    sweep_chk();

    // reset during RMW
    send(OP_FILL, 5, 22'h2ABCDE, 0);
    send(OP_MARK_DIRTY, 5, 22'h2ABCDE, 0);
    rst_n = 0;
    #1 rst_chk("rst_rmw");
    @(negedge clk); rst_n = 1;
    sweep_chk();
    send(OP_LOOKUP, 5, 22'h2ABCDE, 0);
    expect_resp("post_rst", 0, 0, 22'h0);

    repeat (3) @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_tag_ctrl.md
Name: dcache_tag_ctrl

Overview:
- Initiator side of the 1RW OpenRAM `dcache_tag_array` port (16 sets x 24 bits). Drives csb/web/addr/din and samples dout.
- Accepts tag operations from the dcache FSM over a valid/ready handshake and returns a one-cycle response with hit/dirty/stored tag.
- Clears every set after reset (init sweep) so all entries start invalid.

Parameters:
- SET_BITS, 4, SRAM address width; sets = 2**SET_BITS
- TAG_BITS, 22, tag width; entry = {valid, dirty, tag} = TAG_BITS+2 = 24 bits

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on this posedge when req_valid=1
- req_op  in  2  0 LOOKUP, 1 FILL, 2 MARK_DIRTY, 3 INVAL
- req_set  in  SET_BITS  set index
- req_tag  in  TAG_BITS  tag to compare or write
- req_dirty  in  1  dirty bit written by FILL
- resp_valid  out  1  one-cycle response pulse
- resp_hit  out  1  stored valid=1 and stored tag == req_tag (LOOKUP, MARK_DIRTY); 0 otherwise
- resp_dirty  out  1  stored dirty bit before the operation
- resp_tag  out  TAG_BITS  stored tag before the operation (victim address)
- init_done  out  1  sweep complete
- sram_csb  out  1  to csb0, active low
- sram_web  out  1  to web0, active low
- sram_addr  out  SET_BITS  to addr0
- sram_din  out  TAG_BITS+2  to din0
- sram_dout  in  TAG_BITS+2  from dout0

Behaviour:
- SRAM port signals are combinational from state and request. The SRAM captures them at posedge; dout is valid from negedge+DELAY until the next posedge+T_HOLD.
- sram_dout is sampled only at the posedge that ends the read cycle. It is X at all other times.
- Idle port drive: sram_csb=1, sram_web=1, addr=0, din=0.
- Reset values: state=INIT, sweep counter=0, req_ready=0, resp_valid=0, resp_hit=0, resp_dirty=0, resp_tag=0, init_done=0.
- States: INIT, IDLE, RMW.
- INIT:
  - Each cycle drives a write of 0 to the set given by the sweep counter, then increments the counter.
  - After the write to set 2**SET_BITS-1, go to IDLE; init_done=1 from that edge on.
  - req_ready=0 throughout. The sweep takes 16 cycles.
- IDLE:
  - req_ready=1.
  - On accept, the port is driven in the same cycle: csb=0, addr=req_set.
  - web=0 for FILL/INVAL, otherwise web=1.
  - FILL din = {1, req_dirty, req_tag}. INVAL din = 0.
  - Request fields are registered at the accept edge.
- LOOKUP: response is registered at the next posedge from sram_dout. resp_valid is high exactly one cycle, starting one cycle after accept. Stays in IDLE; back-to-back accepts are allowed, throughput 1/cycle.
- FILL/INVAL: resp_valid next cycle with resp_hit=0, resp_dirty=0, resp_tag=0. No read is performed.
- MARK_DIRTY:
  - The cycle after accept is RMW, with req_ready=0.
  - In RMW, evaluate the hit from sram_dout combinationally.
  - If hit: drive a write of {1, 1, stored tag} to the registered set. If miss: csb=1.
  - resp_valid is registered at the end of RMW, with the pre-write resp_dirty/resp_tag.
  - Return to IDLE.
- Read after write to the same set on the next cycle must return the new value: the SRAM writes at negedge and the next capture is the following posedge.
- No response backpressure; the consumer must take resp in its valid cycle.
- req_ready=0 while !init_done; requests are ignored, not queued.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately, and sram_csb=1 combinationally.
  - The sweep restarts at set 0.
  - An SRAM write already captured may complete; the sweep overwrites it.
- Unused req_tag/req_dirty on ops that ignore them are don't-care.

Decomposition:
- Package dcache_tag_pkg holds:
  - the op enum
  - the entry struct {valid, dirty, tag}
  - SET_BITS/TAG_BITS default constants
  - the state enum
- No sub-module. Tag compare is inline.

Test Plan:
- Reset release -> 16 consecutive writes of 0 to addr 0..15; init_done=1 and req_ready=1 in cycle 17; a LOOKUP of any set returns hit=0, dirty=0, tag=0.
- FILL set 5 tag 0x2ABCDE dirty 0, then LOOKUP set 5 tag 0x2ABCDE on the next cycle -> resp_hit=1, resp_dirty=0, resp_tag=0x2ABCDE one cycle after the LOOKUP accept.
- LOOKUP set 5 tag 0x000001 after the above -> resp_hit=0, resp_tag=0x2ABCDE (victim reported).
- MARK_DIRTY set 5 tag 0x2ABCDE -> req_ready=0 for one cycle, resp_hit=1, resp_dirty=0; a following LOOKUP -> resp_dirty=1. MARK_DIRTY on a miss (set 6) -> no SRAM write (csb stays 1 in RMW).
- INVAL set 5 then LOOKUP set 5 -> resp_hit=0, tag=0.
- Assert rst_n at sweep step 7 and again during RMW -> all outputs 0 immediately, csb=1, sweep restarts at addr 0; LOOKUP set 5 after init -> hit=0.
